sram_port_arbiter: RTL and testbench

Shares one synchronous single-port SRAM between the fetch requester (read-only instruction stream) and the memory-stage requester (loads/stores). Arbitrates each cycle, drives the shared SRAM port, returns grants that fetch/mem use to build their stall terms, and routes read data back one cycle later to the requester that owned the access. Sits between the pipeline's SRAM-side outputs and the physical SRAM.

---
 rtl/sram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Fetch/mem arbiter for one shared single-port SRAM, with 1-cycle read return.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of data priority.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        inst_req_en,
  input  logic [31:0] inst_req_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req_en,
  input  logic [3:0]  data_req_we,
  input  logic [31:0] data_req_addr,
  input  logic [31:0] data_req_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  logic [1:0] rsp_owner;
  logic       inst_win;
  logic       data_win;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  logic last_gnt;

  always_comb begin
    inst_win = 1'b0;
    data_win = 1'b0;
    if (!reset) begin
      if (inst_req_en && data_req_en) begin
        inst_win = (last_gnt == GNT_DATA);
        data_win = (last_gnt == GNT_INST);
      end else begin
        inst_win = inst_req_en;
        data_win = data_req_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= GNT_INST;
    end else if (inst_win) begin
      last_gnt <= GNT_INST;
    end else if (data_win) begin
      last_gnt <= GNT_DATA;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    inst_win = 1'b0;
    data_win = 1'b0;
    if (!reset) begin
      if (inst_req_en && data_req_en) begin
        inst_win = starved;
        data_win = !starved;
      end else begin
        inst_win = inst_req_en;
        data_win = data_req_en;
      end
    end
  end

  // Counts consecutive denied fetch cycles; any break in the run clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (inst_req_en && !inst_win) begin
      if (!starved) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`endif

  assign inst_gnt = inst_win;
  assign data_gnt = data_win;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    unique case (1'b1)
      inst_win: begin
        sram_en   = 1'b1;
        sram_addr = inst_req_addr;
      end
      data_win: begin
        sram_en    = 1'b1;
        sram_we    = data_req_we;
        sram_addr  = data_req_addr;
        sram_wdata = data_req_wdata;
      end
      default: ;
    endcase
  end

  // Flushed fetches still hit the SRAM but never return data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_owner <= OWN_NONE;
    end else if (inst_win && !flush) begin
      rsp_owner <= OWN_INST;
    end else if (data_win && (data_req_we == 4'h0)) begin
      rsp_owner <= OWN_DATA;
    end else begin
      rsp_owner <= OWN_NONE;
    end
  end

  // A response still in flight when reset arrives is dropped.
  assign inst_rvalid = !reset && (rsp_owner == OWN_INST);
  assign data_rvalid = !reset && (rsp_owner == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a response scoreboard.
// Build option: ARB_ROUND_ROBIN_EN runs the round-robin sequence.
module tb_sram_port_arbiter;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        inst_req_en = 1'b0;
  logic [31:0] inst_req_addr = 32'h0;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req_en = 1'b0;
  logic [3:0]  data_req_we = 4'h0;
  logic [31:0] data_req_addr = 32'h0;
  logic [31:0] data_req_wdata = 32'h0;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  rsp_t        sb[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] shadow[logic [31:0]];

  sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inst_req_en(inst_req_en), .inst_req_addr(inst_req_addr),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req_en(data_req_en), .data_req_we(data_req_we),
    .data_req_addr(data_req_addr), .data_req_wdata(data_req_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'hc001d00d;
  endfunction

  // Behavioural SRAM: one-cycle read, byte-enabled write.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we != 4'h0) begin
        logic [31:0] w;
        w = mem.exists(sram_addr) ? mem[sram_addr] : pat(sram_addr);
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
        mem[sram_addr] = w;
      end else begin
        sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : pat(sram_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // eg: 0 none, 1 inst, 2 data expected to win this cycle
  task automatic step(input logic ie, input logic [31:0] ia,
                      input logic de, input logic [3:0] dwe,
                      input logic [31:0] da, input logic [31:0] dwd,
                      input logic fl, input logic rs, input int eg);
    rsp_t e;
    logic [31:0] w;
    @(negedge clk);
    inst_req_en = ie; inst_req_addr = ia;
    data_req_en = de; data_req_we = dwe;
    data_req_addr = da; data_req_wdata = dwd;
    flush = fl; reset = rs;
    #1;
    e.kind = 2'd0; e.data = 32'h0;
    if (sb.size() > 0) e = sb.pop_front();
    if (rs) e.kind = 2'd0;
    chk("inst_rvalid", 32'(inst_rvalid), 32'(e.kind == 2'd1));
    chk("data_rvalid", 32'(data_rvalid), 32'(e.kind == 2'd2));
    if (e.kind == 2'd1) chk("inst_rdata", inst_rdata, e.data);
    if (e.kind == 2'd2) chk("data_rdata", data_rdata, e.data);
    chk("inst_gnt", 32'(inst_gnt), 32'(eg == 1));
    chk("data_gnt", 32'(data_gnt), 32'(eg == 2));
    chk("sram_en", 32'(sram_en), 32'(eg != 0));
    chk("sram_we", 32'(sram_we), (eg == 2) ? 32'(dwe) : 32'h0);
    chk("sram_addr", sram_addr, (eg == 1) ? ia : (eg == 2) ? da : 32'h0);
    chk("sram_wdata", sram_wdata, (eg == 2) ? dwd : 32'h0);
    e.kind = 2'd0; e.data = 32'h0;
    if (!rs && eg == 1 && !fl) begin
      e.kind = 2'd1;
      e.data = shadow.exists(ia) ? shadow[ia] : pat(ia);
    end else if (!rs && eg == 2 && dwe == 4'h0) begin
      e.kind = 2'd2;
      e.data = shadow.exists(da) ? shadow[da] : pat(da);
    end else if (!rs && eg == 2) begin
      w = shadow.exists(da) ? shadow[da] : pat(da);
      for (int b = 0; b < 4; b++)
        if (dwe[b]) w[b*8 +: 8] = dwd[b*8 +: 8];
      shadow[da] = w;
    end
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    step(1'b1, 32'h40, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1, 0);
    idle();
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h1c000000 + 32'(i * 4), 1'b1, 4'h0,
           32'h200 + 32'(i * 4), 32'h0, 1'b0, 1'b0, (i % 2 == 0) ? 2 : 1);
    step(1'b1, 32'h1c000040, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h240, 32'h0, 1'b0, 1'b0, 2);
    step(1'b1, 32'h1c000044, 1'b1, 4'h0, 32'h244, 32'h0, 1'b0, 1'b0, 1);
    idle();
`else
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h1c000000 + 32'(i * 4), 1'b0, 4'h0, 32'h0, 32'h0,
           1'b0, 1'b0, 1);
    idle();
    // Both requesting: four data wins, then starvation forces fetch.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h1c000100, 1'b1, (i == 2) ? 4'hf : 4'h0,
           32'h200 + 32'(i * 4), 32'h11110000 + 32'(i), 1'b0, 1'b0,
           (i == 4 || i == 9) ? 1 : 2);
    idle();
    step(1'b1, 32'h1c000200, 1'b1, 4'hf, 32'h100, 32'hdeadbeef,
         1'b0, 1'b0, 2);
    step(1'b1, 32'h1c000200, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0, 2);
    step(1'b0, 32'h0, 1'b1, 4'h3, 32'h104, 32'h0000abcd, 1'b0, 1'b0, 2);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0, 1'b0, 2);
    idle();
    // Flush kills only the fetch granted in the same cycle.
    step(1'b1, 32'h1c000300, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    step(1'b1, 32'h1c000304, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    step(1'b1, 32'h1c000308, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 1'b0, 2);
    idle();
    // Reset with a data read in flight, starvation count part-way.
    step(1'b1, 32'h1c000400, 1'b1, 4'h0, 32'h204, 32'h0, 1'b0, 1'b0, 2);
    step(1'b1, 32'h1c000400, 1'b1, 4'h0, 32'h208, 32'h0, 1'b0, 1'b0, 2);
    step(1'b1, 32'h1c000400, 1'b1, 4'h0, 32'h20c, 32'h0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h1c000400, 1'b1, 4'h0, 32'h210 + 32'(i * 4), 32'h0,
           1'b0, 1'b0, (i == 4) ? 1 : 2);
    idle();
`endif
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
